// File: rtl/video_window_mux_pkg.sv
// Shared types for the video windowing stage: window modes, config field
// codes and the per-window register struct.
// Optional border support is enabled with VIDEO_WINDOW_MUX_BORDER_EN.
package video_pkg;

    // Geometry width used by the window struct; the top's CW must match it.
    localparam int CW_DEF = 13;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_FILL  = 2'd1,
        MODE_INV   = 2'd2,
        MODE_BLANK = 2'd3
    } mode_e;

    localparam logic [2:0] SEL_X      = 3'd0;
    localparam logic [2:0] SEL_Y      = 3'd1;
    localparam logic [2:0] SEL_W      = 3'd2;
    localparam logic [2:0] SEL_H      = 3'd3;
    localparam logic [2:0] SEL_CTRL   = 3'd4;
    localparam logic [2:0] SEL_BORDER = 3'd5;

    typedef struct packed {
        logic              en;
        mode_e             mode;
        logic [CW_DEF-1:0] x;
        logic [CW_DEF-1:0] y;
        logic [CW_DEF-1:0] w;
        logic [CW_DEF-1:0] h;
`ifdef VIDEO_WINDOW_MUX_BORDER_EN
        logic [1:0]        t;
`endif
    } win_t;

endpackage

// File: rtl/video_window_mux_if.sv
// Pixel, sync and config signals of the windowing stage bundled as one
// interface. The source side uses master, the windowing stage uses slave.
interface video_window_mux_if #(
    parameter int DW = 8,
    parameter int CW = 13
);
    logic          vs;
    logic          vpg_de;
    logic [DW-1:0] in_rgb_r;
    logic [DW-1:0] in_rgb_g;
    logic [DW-1:0] in_rgb_b;
    logic          cfg_we;
    logic [1:0]    cfg_win;
    logic [2:0]    cfg_sel;
    logic [CW-1:0] cfg_data;
    logic          out_vs;
    logic          out_de;
    logic [DW-1:0] out_rgb_r;
    logic [DW-1:0] out_rgb_g;
    logic [DW-1:0] out_rgb_b;

    modport master (
        output vs, vpg_de, in_rgb_r, in_rgb_g, in_rgb_b,
        output cfg_we, cfg_win, cfg_sel, cfg_data,
        input  out_vs, out_de, out_rgb_r, out_rgb_g, out_rgb_b
    );

    modport slave (
        input  vs, vpg_de, in_rgb_r, in_rgb_g, in_rgb_b,
        input  cfg_we, cfg_win, cfg_sel, cfg_data,
        output out_vs, out_de, out_rgb_r, out_rgb_g, out_rgb_b
    );
endinterface

// File: rtl/video_window_mux_win_hit.sv
// Combinational hit test of one window against the current h/v position.
// With VIDEO_WINDOW_MUX_BORDER_EN it also flags pixels on the window outline.
module video_win_hit
    import video_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  win_t          win_i,
    input  logic [CW-1:0] h_i,
    input  logic [CW-1:0] v_i,
`ifdef VIDEO_WINDOW_MUX_BORDER_EN
    output logic          border_o,
`endif
    output logic          hit_o
);

    logic [CW:0] x_end;
    logic [CW:0] y_end;
    logic        in_x;
    logic        in_y;

    // Window extents are summed one bit wider so x + w never wraps.
    always_comb begin
        x_end = {1'b0, win_i.x} + {1'b0, win_i.w};
        y_end = {1'b0, win_i.y} + {1'b0, win_i.h};
        in_x  = ({1'b0, h_i} >= {1'b0, win_i.x}) && ({1'b0, h_i} < x_end);
        in_y  = ({1'b0, v_i} >= {1'b0, win_i.y}) && ({1'b0, v_i} < y_end);
        hit_o = win_i.en && in_x && in_y;
    end

`ifdef VIDEO_WINDOW_MUX_BORDER_EN
    logic [CW:0] d_left;
    logic [CW:0] d_right;
    logic [CW:0] d_top;
    logic [CW:0] d_bot;
    logic [CW:0] thick;

    // Distances to each edge are only meaningful inside the window, so the
    // result is gated by the hit.
    always_comb begin
        thick    = {{(CW-1){1'b0}}, win_i.t};
        d_left   = {1'b0, h_i} - {1'b0, win_i.x};
        d_right  = x_end - (CW+1)'(1) - {1'b0, h_i};
        d_top    = {1'b0, v_i} - {1'b0, win_i.y};
        d_bot    = y_end - (CW+1)'(1) - {1'b0, v_i};
        border_o = hit_o && ((d_left < thick) || (d_right < thick) ||
                             (d_top < thick) || (d_bot < thick));
    end
`endif

endmodule

// File: rtl/video_window_mux.sv
// Frame-synchronous windowing stage on the RGB pixel path. NWIN rectangular
// windows with per-window mode; config is double-buffered and takes effect
// at the vs rising edge. Output is registered, 1 clock behind the input.
// Optional feature macro: VIDEO_WINDOW_MUX_BORDER_EN (per-window outline).
module video_window_mux
    import video_pkg::*;
#(
    parameter int            DW      = 8,
    parameter int            CW      = CW_DEF,
    parameter int            NWIN    = 2,
    parameter logic [DW-1:0] FILL_R  = 8'hFF,
    parameter logic [DW-1:0] FILL_G  = 8'h00,
    parameter logic [DW-1:0] FILL_B  = 8'h00,
    parameter bit            BG_PASS = 1'b0
) (
    input logic               vpg_pclk,
    input logic               rst_n,
    video_window_mux_if.slave vif
);

    localparam int PW = 3 * DW;

    logic          vs_q;
    logic          de_q;
    logic          vs_rise;
    logic          de_fall;
    logic [CW-1:0] cnt_h_q, cnt_h_d;
    logic [CW-1:0] cnt_v_q, cnt_v_d;

    win_t          shadow_q [NWIN];
    win_t          shadow_d [NWIN];
    win_t          active_q [NWIN];

    logic [NWIN-1:0] hit;
    logic            sel_hit;
    mode_e           sel_mode;
    logic [PW-1:0]   in_px;
    logic [PW-1:0]   fill_px;
    logic [PW-1:0]   px_d;
    logic [PW-1:0]   out_px_q;
    logic            out_vs_q;
    logic            out_de_q;

`ifdef VIDEO_WINDOW_MUX_BORDER_EN
    logic [NWIN-1:0] border;
    logic            sel_border;
`endif

    assign vs_rise = vif.vs && !vs_q;
    assign de_fall = de_q && !vif.vpg_de;
    assign in_px   = {vif.in_rgb_r, vif.in_rgb_g, vif.in_rgb_b};
    assign fill_px = {FILL_R, FILL_G, FILL_B};

    // Next horizontal/vertical position; vs restart wins over a line end.
    always_comb begin
        cnt_h_d = vif.vpg_de ? cnt_h_q + CW'(1) : '0;
        cnt_v_d = cnt_v_q;
        if (vs_rise) begin
            cnt_v_d = '0;
        end else if (de_fall && (cnt_v_q != {CW{1'b1}})) begin
            cnt_v_d = cnt_v_q + CW'(1);
        end
    end

    // Edge-detect delays and pixel position counters.
    always_ff @(posedge vpg_pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q    <= 1'b0;
            de_q    <= 1'b0;
            cnt_h_q <= '0;
            cnt_v_q <= '0;
        end else begin
            vs_q    <= vif.vs;
            de_q    <= vif.vpg_de;
            cnt_h_q <= cnt_h_d;
            cnt_v_q <= cnt_v_d;
        end
    end

    // Shadow register write; window indices without a window are dropped.
    always_comb begin
        for (int i = 0; i < NWIN; i++) begin
            shadow_d[i] = shadow_q[i];
            if (vif.cfg_we && (vif.cfg_win == 2'(i))) begin
                case (vif.cfg_sel)
                    SEL_X:    shadow_d[i].x    = vif.cfg_data;
                    SEL_Y:    shadow_d[i].y    = vif.cfg_data;
                    SEL_W:    shadow_d[i].w    = vif.cfg_data;
                    SEL_H:    shadow_d[i].h    = vif.cfg_data;
                    SEL_CTRL: begin
                        shadow_d[i].en   = vif.cfg_data[2];
                        shadow_d[i].mode = mode_e'(vif.cfg_data[1:0]);
                    end
`ifdef VIDEO_WINDOW_MUX_BORDER_EN
                    SEL_BORDER: shadow_d[i].t = vif.cfg_data[1:0];
`endif
                    default: ;
                endcase
            end
        end
    end

    // Shadow set holds pending config written at any time.
    always_ff @(posedge vpg_pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NWIN; i++) shadow_q[i] <= '0;
        end else begin
            for (int i = 0; i < NWIN; i++) shadow_q[i] <= shadow_d[i];
        end
    end

    // Active set is loaded from the pre-write shadow at the vs rising edge.
    always_ff @(posedge vpg_pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NWIN; i++) active_q[i] <= '0;
        end else if (vs_rise) begin
            for (int i = 0; i < NWIN; i++) active_q[i] <= shadow_q[i];
        end
    end

    for (genvar g = 0; g < NWIN; g++) begin : g_hit
        video_win_hit #(.CW(CW)) u_hit (
            .win_i    (active_q[g]),
            .h_i      (cnt_h_q),
            .v_i      (cnt_v_q),
`ifdef VIDEO_WINDOW_MUX_BORDER_EN
            .border_o (border[g]),
`endif
            .hit_o    (hit[g])
        );
    end

    // Lowest-index hit window decides; scanned high to low so it lands last.
    always_comb begin
        sel_hit  = 1'b0;
        sel_mode = MODE_PASS;
`ifdef VIDEO_WINDOW_MUX_BORDER_EN
        sel_border = 1'b0;
`endif
        for (int i = NWIN - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel_hit  = 1'b1;
                sel_mode = active_q[i].mode;
`ifdef VIDEO_WINDOW_MUX_BORDER_EN
                sel_border = border[i];
`endif
            end
        end
    end

    // Output pixel selection; blanking intervals always produce black.
    always_comb begin
        px_d = '0;
        if (vif.vpg_de) begin
            if (sel_hit) begin
                case (sel_mode)
                    MODE_PASS: px_d = in_px;
                    MODE_FILL: px_d = fill_px;
                    MODE_INV:  px_d = ~in_px;
                    default:   px_d = '0;
                endcase
`ifdef VIDEO_WINDOW_MUX_BORDER_EN
                if (sel_border) px_d = fill_px;
`endif
            end else if (BG_PASS) begin
                px_d = in_px;
            end
        end
    end

    // Output register: pixel, de and vs all share the 1-clock latency.
    always_ff @(posedge vpg_pclk or negedge rst_n) begin
        if (!rst_n) begin
            out_vs_q <= 1'b0;
            out_de_q <= 1'b0;
            out_px_q <= '0;
        end else begin
            out_vs_q <= vif.vs;
            out_de_q <= vif.vpg_de;
            out_px_q <= px_d;
        end
    end

    assign vif.out_vs    = out_vs_q;
    assign vif.out_de    = out_de_q;
    assign vif.out_rgb_r = out_px_q[PW-1:2*DW];
    assign vif.out_rgb_g = out_px_q[2*DW-1:DW];
    assign vif.out_rgb_b = out_px_q[DW-1:0];

endmodule

// File: tb/tb_video_window_mux.sv
// Directed bench for video_window_mux: reset, fill window, overlap priority,
// double-buffered config, edge geometry and (optionally) window borders.
module tb_video_window_mux;
    import video_pkg::*;

    localparam int DW = 8;
    localparam int CW = 13;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    video_window_mux_if #(.DW(DW), .CW(CW)) vif ();

    video_window_mux #(.DW(DW), .CW(CW), .NWIN(2)) dut (
        .vpg_pclk (clk),
        .rst_n    (rst_n),
        .vif      (vif.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int ln    = 0;

    // Hand-maintained copy of the window set expected to be active this frame.
    bit ex_en   [2];
    int ex_mode [2];
    int ex_x    [2];
    int ex_y    [2];
    int ex_w    [2];
    int ex_h    [2];
    int ex_t    [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_pix(input int v, input int h, input logic [7:0] iv);
        logic [23:0] inp;
        inp = {iv, iv, iv};
        for (int i = 0; i < 2; i++) begin
            if (ex_en[i] && h >= ex_x[i] && h < ex_x[i] + ex_w[i] &&
                v >= ex_y[i] && v < ex_y[i] + ex_h[i]) begin
`ifdef VIDEO_WINDOW_MUX_BORDER_EN
                if (ex_t[i] > 0 && (h < ex_x[i] + ex_t[i] || h >= ex_x[i] + ex_w[i] - ex_t[i] ||
                                    v < ex_y[i] + ex_t[i] || v >= ex_y[i] + ex_h[i] - ex_t[i]))
                    return 24'hFF0000;
`endif
                case (ex_mode[i])
                    0:       return inp;
                    1:       return 24'hFF0000;
                    2:       return ~inp;
                    default: return 24'h000000;
                endcase
            end
        end
        return 24'h000000;
    endfunction

    function automatic logic [23:0] out_px();
        return {vif.out_rgb_r, vif.out_rgb_g, vif.out_rgb_b};
    endfunction

    task automatic set_ex(input int i, input bit en, input int mode, input int x,
                          input int y, input int w, input int h, input int t);
        ex_en[i] = en; ex_mode[i] = mode; ex_x[i] = x; ex_y[i] = y;
        ex_w[i] = w; ex_h[i] = h; ex_t[i] = t;
    endtask

    task automatic step(input bit v, input bit d, input logic [7:0] px);
        @(negedge clk);
        vif.vs = v; vif.vpg_de = d;
        vif.in_rgb_r = px; vif.in_rgb_g = px; vif.in_rgb_b = px;
        @(posedge clk);
        #1;
    endtask

    task automatic cfgw(input int w, input int s, input int data);
        @(negedge clk);
        vif.vpg_de = 1'b0;
        vif.cfg_we = 1'b1; vif.cfg_win = 2'(w); vif.cfg_sel = 3'(s); vif.cfg_data = CW'(data);
        @(posedge clk);
        #1;
        vif.cfg_we = 1'b0;
    endtask

    // vs pulse; optionally a config write on the very cycle vs rises.
    task automatic vsync(input bit wr, input int w, input int s, input int data);
        @(negedge clk);
        vif.vs = 1'b1; vif.vpg_de = 1'b0;
        if (wr) begin
            vif.cfg_we = 1'b1; vif.cfg_win = 2'(w); vif.cfg_sel = 3'(s); vif.cfg_data = CW'(data);
        end
        @(posedge clk);
        #1;
        vif.cfg_we = 1'b0;
        chk("out_vs_high", 32'(vif.out_vs), 32'd1);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        ln = 0;
    endtask

    // One active line; long lines are only checked near both ends.
    task automatic line(input int len, input logic [7:0] px, input string tag);
        for (int p = 0; p < len; p++) begin
            step(1'b0, 1'b1, px);
            if (len <= 64 || p < 8 || p >= len - 8)
                chk($sformatf("%s_l%0d_p%0d", tag, ln, p), 32'(out_px()), 32'(exp_pix(ln, p, px)));
        end
        step(1'b0, 1'b0, px);
        chk($sformatf("%s_l%0d_blank_rgb", tag, ln), 32'(out_px()), 32'd0);
        chk($sformatf("%s_l%0d_blank_de", tag, ln), 32'(vif.out_de), 32'd0);
        step(1'b0, 1'b0, 8'h00);
        ln++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vif.vs = 1'b0; vif.vpg_de = 1'b0;
        vif.in_rgb_r = '0; vif.in_rgb_g = '0; vif.in_rgb_b = '0;
        vif.cfg_we = 1'b0; vif.cfg_win = '0; vif.cfg_sel = '0; vif.cfg_data = '0;
        for (int i = 0; i < 2; i++) set_ex(i, 1'b0, 0, 0, 0, 0, 0, 0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rgb", 32'(out_px()), 32'd0);
        chk("rst_de", 32'(vif.out_de), 32'd0);
        chk("rst_vs", 32'(vif.out_vs), 32'd0);
        rst_n = 1'b1;

        // Full-area PASS window, then reset mid-line with de held high
        cfgw(0, 0, 0); cfgw(0, 1, 0); cfgw(0, 2, 50); cfgw(0, 3, 10); cfgw(0, 4, 4);
        vsync(1'b0, 0, 0, 0);
        set_ex(0, 1'b1, 0, 0, 0, 50, 10, 0);
        line(20, 8'h40, "pass");
        for (int p = 0; p < 5; p++) begin
            step(1'b0, 1'b1, 8'h40);
            chk($sformatf("pre_rst_p%0d", p), 32'(out_px()), 32'h404040);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_async_rgb", 32'(out_px()), 32'd0);
        chk("rst_async_de", 32'(vif.out_de), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b1, 8'h40);
            chk($sformatf("rst_hold_c%0d", c), 32'(out_px()), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_after_rgb", 32'(out_px()), 32'd0);
        chk("rst_after_de", 32'(vif.out_de), 32'd1);
        set_ex(0, 1'b0, 0, 0, 0, 0, 0, 0);
        step(1'b0, 1'b0, 8'h00);

        // Single FILL window on line 2, pixels 10..13
        cfgw(0, 0, 10); cfgw(0, 1, 2); cfgw(0, 2, 4); cfgw(0, 3, 1); cfgw(0, 4, 5);
        vsync(1'b0, 0, 0, 0);
        set_ex(0, 1'b1, 1, 10, 2, 4, 1, 0);
        for (int l = 0; l < 4; l++) line(20, 8'h40, "fill");

        // Overlap: INV on 0..7 beats BLANK on 4..11; stray writes ignored
        cfgw(0, 0, 0); cfgw(0, 1, 0); cfgw(0, 2, 8); cfgw(0, 3, 4); cfgw(0, 4, 6);
        cfgw(1, 0, 4); cfgw(1, 1, 0); cfgw(1, 2, 8); cfgw(1, 3, 4); cfgw(1, 4, 7);
        cfgw(2, 4, 5); cfgw(3, 4, 5); cfgw(0, 6, 0); cfgw(0, 7, 0);
        vsync(1'b0, 0, 0, 0);
        set_ex(0, 1'b1, 2, 0, 0, 8, 4, 0);
        set_ex(1, 1'b1, 3, 4, 0, 8, 4, 0);
        line(14, 8'h0F, "ovl");
        line(14, 8'h0F, "ovl");

        // Double buffering: mid-frame write, then write on the vs-edge cycle
        cfgw(1, 4, 0);
        cfgw(0, 0, 0); cfgw(0, 1, 0); cfgw(0, 2, 4); cfgw(0, 3, 8); cfgw(0, 4, 5);
        vsync(1'b0, 0, 0, 0);
        set_ex(1, 1'b0, 0, 0, 0, 0, 0, 0);
        set_ex(0, 1'b1, 1, 0, 0, 4, 8, 0);
        line(10, 8'h40, "dbA");
        cfgw(0, 2, 8);
        line(10, 8'h40, "dbA");
        vsync(1'b1, 0, 2, 2);
        set_ex(0, 1'b1, 1, 0, 0, 8, 8, 0);
        line(10, 8'h40, "dbB");
        line(10, 8'h40, "dbB");
        vsync(1'b0, 0, 0, 0);
        set_ex(0, 1'b1, 1, 0, 0, 2, 8, 0);
        line(10, 8'h40, "dbC");

        // Edge geometry: window against the top of the counter range
        cfgw(0, 0, 8188); cfgw(0, 1, 0); cfgw(0, 2, 8); cfgw(0, 3, 1); cfgw(0, 4, 5);
        vsync(1'b0, 0, 0, 0);
        set_ex(0, 1'b1, 1, 8188, 0, 8, 1, 0);
        line(8192, 8'h40, "edge");

        // Zero width never hits
        cfgw(0, 0, 0); cfgw(0, 2, 0); cfgw(0, 3, 4);
        vsync(1'b0, 0, 0, 0);
        set_ex(0, 1'b1, 1, 0, 0, 0, 4, 0);
        line(20, 8'h40, "w0");

`ifdef VIDEO_WINDOW_MUX_BORDER_EN
        // Border of thickness 1 on a 20x10 PASS window
        cfgw(0, 0, 2); cfgw(0, 1, 0); cfgw(0, 2, 20); cfgw(0, 3, 10); cfgw(0, 4, 4); cfgw(0, 5, 1);
        vsync(1'b0, 0, 0, 0);
        set_ex(0, 1'b1, 0, 2, 0, 20, 10, 1);
        for (int l = 0; l < 12; l++) line(24, 8'h40, "bord");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/video_window_mux.md
Name: video_window_mux

Overview:
- Frame-synchronous windowing stage on the RGB pixel path.
- Applies NWIN runtime-programmable rectangular windows to the incoming video stream.
- Each window has its own mode: pass, solid fill, invert or blank.
- Sits after the pattern/source stage and before the HDMI transmitter. Replaces fixed compile-time crop constants with per-frame programmable geometry.

Parameters:
- DW, 8, bits per colour channel.
- CW, 13, width of the h/v counters and of geometry fields.
- NWIN, 2, number of windows, 1..4.
- FILL_R / FILL_G / FILL_B, 8'hFF / 8'h00 / 8'h00, fill colour for mode FILL.
- BG_PASS, 0, outside all windows: 1 = pass input, 0 = output black.

Ports:
- vpg_pclk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- vs  in  1  vertical sync, active high
- vpg_de  in  1  data enable, active high
- in_rgb_r / in_rgb_g / in_rgb_b  in  DW each  input pixel
- cfg_we  in  1  shadow register write strobe
- cfg_win  in  2  window index, writes to index >= NWIN are ignored
- cfg_sel  in  3  field: 0 = x, 1 = y, 2 = w, 3 = h, 4 = {en, mode[1:0]}; 5..7 ignored
- cfg_data  in  CW  field value; field 4 uses bits [2:0]
- out_vs  out  1  vs delayed to align with pixel
- out_de  out  1  vpg_de delayed to align with pixel
- out_rgb_r / out_rgb_g / out_rgb_b  out  DW each  output pixel

Behaviour:
- Reset (rst_n low, async): cnt_h = 0, cnt_v = 0; all outputs 0; every shadow and active window has en = 0, geometry 0, mode PASS.
- cnt_h: increments each cycle vpg_de = 1; cleared to 0 on any cycle vpg_de = 0. The first pixel of a line sees cnt_h = 0.
- cnt_v:
  - Cleared on the rising edge of vs.
  - Increments on each falling edge of vpg_de, from a 1-cycle delayed copy.
  - First active line is 0.
  - Saturates at 2^CW-1, no wrap.
- Config is double-buffered:
  - cfg_we writes the shadow set.
  - The shadow set is copied to the active set on the cycle the vs rising edge is detected.
  - If cfg_we coincides with that cycle, the active set takes the pre-write shadow value; the write lands in shadow and applies next frame.
- Hit test for window i (en = 1): x <= cnt_h < x + w and y <= cnt_v < y + h.
  - Sums are computed in CW+1 bits, so no wrap.
  - w = 0 or h = 0 means the window never hits.
- Priority: the lowest-index hit window supplies the mode.
- Modes:
  - 0 PASS: input pixel.
  - 1 FILL: FILL_* colour.
  - 2 INV: bitwise ~input.
  - 3 BLANK: zeros.
- No hit: per BG_PASS.
- Pixels with vpg_de = 0 output zeros regardless of hit.
- Latency: exactly 1 clock, input to out_rgb_*. out_de and out_vs are registered copies with the same 1-clock latency.
- Reset mid-frame: counters and outputs are zeroed immediately. The first valid frame starts at the next vs rising edge; before it, cnt_v counts from 0.

Optional Feature:
- Macro: VIDEO_WINDOW_MUX_BORDER_EN.
- Defined:
  - Adds shadow/active field cfg_sel = 5, holding a 2-bit border thickness t per window (0 = none).
  - Hit pixels within t pixels of any window edge output the FILL colour, whatever the mode.
  - Priority among windows is unchanged.
- Undefined: cfg_sel = 5 is ignored; no border logic is synthesised.

Decomposition:
- Package video_pkg:
  - Mode enum MODE_PASS/FILL/INV/BLANK (2 bits).
  - cfg_sel field codes.
  - Window struct typedef {en, mode, x, y, w, h} parametrised by CW through a localparam default of 13.
- Sub-module video_win_hit: combinational per-window hit (and border) test, instantiated NWIN times in a generate loop.

Test Plan:
- Reset mid-line (rst_n low 3 cycles while vpg_de = 1) -> outputs 0 during reset and 1 cycle after; cnt_h restarts at 0 on the next de.
- Window 0 = {x 10, y 2, w 4, h 1, FILL}, 1920x1080 frame of constant input 0x40 -> line 2, pixels 10..13 = FF/00/00 one clock late; all other pixels 0 (BG_PASS = 0).
- Overlap: window 0 INV at x 0..7, window 1 BLANK at x 4..11, input 0x0F -> pixels 0..7 = 0xF0, pixels 8..11 = 0x00.
- cfg write of w = 8 mid-frame -> current frame still uses old w; change appears from the next vs rising edge. Write on the exact vs-edge cycle -> takes effect one frame later.
- Edge geometry: x = 2^CW-4, w = 8 -> hits cnt_h 8188..8191 only, no wrap to 0. w = 0 -> no hit.
- BORDER_EN, t = 1, window 20x10 in PASS -> outline pixels = FILL colour, interior passes input.
